instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have: in_valid  in  1  request valid.
REQ-004 SHALL have: in_ready  out  1  request accepted when in_valid & in_ready at a rising clk edge.
REQ-005 SHALL have: fmt  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101-111 illegal.
REQ-006 SHALL have: opcode in 7; rd in 5; funct3 in 3; rs1 in 5; rs2 in 5  instruction fields.
REQ-007 SHALL have: imm  in  32  signed byte immediate (B/J byte offset; U full value with low 12 bits zero).
REQ-008 SHALL have: out_valid  out  1  encoded word valid.
REQ-009 SHALL have: out_ready  in  1  word consumed when out_valid & out_ready at a rising clk edge.
REQ-010 SHALL have: ins  out  32  encoded instruction word.
REQ-011 SHALL have: err  out  1  word travels with a range, alignment or format error.
REQ-012 SHALL have: err_cnt  out  8  saturating count of errored words accepted.

Function
REQ-013 SHALL pack: I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-014 SHALL pack: B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
REQ-015 SHALL pack: J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; U {imm[31:12],rd,opcode}.
REQ-016 SHALL encode illegal fmt as ins = 0 with err = 1, regardless of configuration.
REQ-017 SHALL be a two-stage pipeline: S1 registers the request; S2 registers the packed word, err and outputs.
REQ-018 SHALL have latency 2 cycles from acceptance to out_valid when out_ready is held high.
REQ-019 SHALL sustain one request per cycle with out_ready held high.
REQ-020 SHALL advance S2 when S2 is empty or out_ready = 1; S1 moves into S2 on that advance.
REQ-021 SHALL drive in_ready = !S1_valid | S2 advancing (combinational from out_ready, no combinational in_valid->in_ready path).
REQ-022 SHALL buffer up to 2 requests under backpressure; no request lost or duplicated.
REQ-023 SHALL hold ins and err stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL increment err_cnt on the cycle an err=1 word enters S2; saturate at 255, no wrap.
REQ-025 SHALL ignore the fields when in_valid = 0; S1 contents change only on acceptance.

Reset
REQ-026 SHALL on rst_n low immediately clear: S1/S2 valid, out_valid = 0, ins = 0, err = 0, err_cnt = 0.
REQ-027 SHALL drive in_ready = 1 from the first edge after rst_n deasserts.
REQ-028 SHALL discard any in-flight words on reset mid-operation; no partial word emitted after release.

Configuration
REQ-029 SHALL support macro IMM_RANGE_CHECK_EN.
REQ-030 With IMM_RANGE_CHECK_EN defined, SHALL set err = 1 when:
  - I/S: imm[31:11] not all equal;
  - B: imm[31:12] not all equal, or imm[0] = 1;
  - J: imm[31:20] not all equal, or imm[0] = 1;
  - U: imm[11:0] != 0.
  The word SHALL still be packed per REQ-013..015 using the truncated bits.
REQ-031 Without IMM_RANGE_CHECK_EN, SHALL perform no range check; err and err_cnt count only illegal fmt.

Verification
REQ-032 I: fmt=000, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> ins=0x00500093, err=0, out_valid 2 cycles later.
REQ-033 B: fmt=010, opcode=0x63, rs1=rs2=0, funct3=0, imm=0xFFFFFFFC -> ins=0xFE000EE3, err=0.
REQ-034 J/U back-to-back:
  - fmt=011, opcode=0x6F, rd=1, imm=8 -> ins=0x008000EF;
  - next cycle fmt=100, opcode=0x37, rd=5, imm=0x12345000 -> ins=0x123452B7 one cycle later.
REQ-035 Error (macro on): fmt=000, imm=2048 -> err=1, err_cnt=1; fmt=110 -> ins=0, err=1, err_cnt=2.
REQ-036 Backpressure: out_ready=0, 3 requests offered -> 2 accepted, then in_ready=0; ins held stable; raise out_ready -> all 3 emitted in order.
REQ-037 Reset mid-stream with 2 words buffered -> out_valid=0, err_cnt=0 immediately; nothing emitted after release.

Source files
------------

// File: rtl/instruction_encoder_if.sv
// Request/response bundle for instruction_encoder: field-level request in,
// encoded 32-bit instruction word out, valid/ready on both sides.
interface instruction_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ins;
    logic        err;
    logic [7:0]  err_cnt;

    modport master (
        output in_valid, fmt, opcode, rd, funct3, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, ins, err, err_cnt
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, ins, err, err_cnt
    );
endinterface

// File: rtl/instruction_encoder.sv
// Two-stage RISC-V style instruction encoder (I/S/B/J/U) with valid/ready flow.
// Optional macro IMM_RANGE_CHECK_EN adds immediate range/alignment error flagging.
module instruction_encoder (
    input logic                  clk,
    input logic                  rst_n,
    instruction_encoder_if.slave bus
);
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    req_t        s1_req_q, s1_req_d;
    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] ins_q, ins_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        s2_adv;
    logic        in_ready_w;
    logic        accept;
    logic [31:0] pack_ins;
    logic        fmt_err;
    logic        rng_err;

    // Pack the S1 request; truncated immediate bits are used even when out of range.
    always_comb begin
        pack_ins = '0;
        fmt_err  = 1'b0;
        rng_err  = 1'b0;
        case (s1_req_q.fmt)
            3'b000: pack_ins = {s1_req_q.imm[11:0], s1_req_q.rs1, s1_req_q.funct3,
                                s1_req_q.rd, s1_req_q.opcode};
            3'b001: pack_ins = {s1_req_q.imm[11:5], s1_req_q.rs2, s1_req_q.rs1,
                                s1_req_q.funct3, s1_req_q.imm[4:0], s1_req_q.opcode};
            3'b010: pack_ins = {s1_req_q.imm[12], s1_req_q.imm[10:5], s1_req_q.rs2,
                                s1_req_q.rs1, s1_req_q.funct3, s1_req_q.imm[4:1],
                                s1_req_q.imm[11], s1_req_q.opcode};
            3'b011: pack_ins = {s1_req_q.imm[20], s1_req_q.imm[10:1], s1_req_q.imm[11],
                                s1_req_q.imm[19:12], s1_req_q.rd, s1_req_q.opcode};
            3'b100: pack_ins = {s1_req_q.imm[31:12], s1_req_q.rd, s1_req_q.opcode};
            default: fmt_err = 1'b1;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        case (s1_req_q.fmt)
            3'b000, 3'b001:
                rng_err = !((&s1_req_q.imm[31:11]) || !(|s1_req_q.imm[31:11]));
            3'b010:
                rng_err = !((&s1_req_q.imm[31:12]) || !(|s1_req_q.imm[31:12]))
                          || s1_req_q.imm[0];
            3'b011:
                rng_err = !((&s1_req_q.imm[31:20]) || !(|s1_req_q.imm[31:20]))
                          || s1_req_q.imm[0];
            3'b100:
                rng_err = |s1_req_q.imm[11:0];
            default: rng_err = 1'b0;
        endcase
`endif
    end

    // S2 drains when empty or consumed; S1 may refill in the same cycle it empties.
    always_comb begin
        s2_adv     = !s2_valid_q || bus.out_ready;
        in_ready_w = !s1_valid_q || s2_adv;
        accept     = bus.in_valid && in_ready_w;

        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_req_d   = '{fmt: bus.fmt, opcode: bus.opcode, rd: bus.rd, funct3: bus.funct3,
                           rs1: bus.rs1, rs2: bus.rs2, imm: bus.imm};
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        ins_d      = ins_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                ins_d = pack_ins;
                err_d = fmt_err || rng_err;
                if ((fmt_err || rng_err) && (err_cnt_q != 8'hFF))
                    err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s2_valid_q <= 1'b0;
            ins_q      <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            s2_valid_q <= s2_valid_d;
            ins_q      <= ins_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = s2_valid_q;
    assign bus.ins       = ins_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized and directed bench for instruction_encoder with a queue-based reference model.
module tb_instruction_encoder;
    logic clk;
    logic rst_n;
    instruction_encoder_if bus();

    instruction_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        err;
    } exp_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference encoding from field positions, using shifts and masks.
    function automatic exp_t exp_word(input logic [2:0] f, input logic [6:0] op,
                                      input logic [4:0] rd, input logic [2:0] f3,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [31:0] imm);
        exp_t e;
        logic [31:0] o, d, u, a, b;
`ifdef IMM_RANGE_CHECK_EN
        int s;
        s = int'(imm);
`endif
        o = 32'(op);
        d = 32'(rd) << 7;
        u = 32'(f3) << 12;
        a = 32'(rs1) << 15;
        b = 32'(rs2) << 20;
        e.err = 1'b0;
        case (f)
            3'd0: e.ins = ((imm & 32'hFFF) << 20) | a | u | d | o;
            3'd1: e.ins = (((imm >> 5) & 32'h7F) << 25) | b | a | u | ((imm & 32'h1F) << 7) | o;
            3'd2: e.ins = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | b | a | u
                          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | o;
            3'd3: e.ins = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                          | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
            3'd4: e.ins = (imm & 32'hFFFFF000) | d | o;
            default: begin
                e.ins = 32'h0;
                e.err = 1'b1;
            end
        endcase
`ifdef IMM_RANGE_CHECK_EN
        case (f)
            3'd0, 3'd1: if (s < -2048 || s > 2047) e.err = 1'b1;
            3'd2: if (s < -4096 || s > 4095 || (imm & 32'h1) != 0) e.err = 1'b1;
            3'd3: if (s < -1048576 || s > 1048575 || (imm & 32'h1) != 0) e.err = 1'b1;
            3'd4: if ((imm & 32'hFFF) != 0) e.err = 1'b1;
            default: ;
        endcase
`endif
        return e;
    endfunction

    task automatic set_req(input logic v, input logic [2:0] f, input logic [6:0] op,
                           input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        bus.in_valid = v;
        bus.fmt      = f;
        bus.opcode   = op;
        bus.rd       = rd;
        bus.funct3   = f3;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.imm      = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_req(1'b0, 3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 32'd0);
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_req(1'b0, 3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 32'd0);
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.ins !== 32'h0 || bus.err !== 1'b0 || bus.err_cnt !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b ins=%h err=%b cnt=%0d, want 0/0/0/0",
                     bus.out_valid, bus.ins, bus.err, bus.err_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        apply_reset();
        bus.out_ready = 1'b1;
        set_req(1'b1, 3'b000, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5);
        tick();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL i_latency_early: got out_valid=%b, want 0", bus.out_valid);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.ins !== 32'h00500093 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL i_encode: got v=%b ins=%h err=%b, want 1/00500093/0", bus.out_valid, bus.ins, bus.err);
        end

        set_req(1'b1, 3'b010, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
        tick();
        bus.in_valid = 1'b0;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.ins !== 32'hFE000EE3 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL b_encode: got v=%b ins=%h err=%b, want 1/fe000ee3/0", bus.out_valid, bus.ins, bus.err);
        end

        set_req(1'b1, 3'b011, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'd8);
        tick();
        set_req(1'b1, 3'b100, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h12345000);
        tick();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.ins !== 32'h008000EF || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL j_encode: got v=%b ins=%h err=%b, want 1/008000ef/0", bus.out_valid, bus.ins, bus.err);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.ins !== 32'h123452B7 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL u_back_to_back: got v=%b ins=%h err=%b, want 1/123452b7/0", bus.out_valid, bus.ins, bus.err);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: got out_valid=%b, want 0", bus.out_valid);
        end
    endtask

    task automatic test_errors();
        exp_t e1;
        int   c1;
        apply_reset();
        bus.out_ready = 1'b1;
        e1 = exp_word(3'b000, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 32'd2048);
        c1 = e1.err ? 1 : 0;
        set_req(1'b1, 3'b000, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 32'd2048);
        tick();
        set_req(1'b1, 3'b110, 7'h13, 5'd3, 3'd1, 5'd2, 5'd4, 32'd7);
        tick();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.ins !== e1.ins || bus.err !== e1.err || bus.err_cnt !== 8'(c1)) begin
            miscompares++;
            $display("FAIL imm_range_word: got ins=%h err=%b cnt=%0d, want %h/%b/%0d",
                     bus.ins, bus.err, bus.err_cnt, e1.ins, e1.err, c1);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.ins !== 32'h0 || bus.err !== 1'b1 || bus.err_cnt !== 8'(c1 + 1)) begin
            miscompares++;
            $display("FAIL illegal_fmt: got v=%b ins=%h err=%b cnt=%0d, want 1/0/1/%0d",
                     bus.out_valid, bus.ins, bus.err, bus.err_cnt, c1 + 1);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        bus.out_ready = 1'b1;
        set_req(1'b1, 3'b111, 7'h01, 5'd0, 3'd0, 5'd0, 5'd0, 32'd0);
        for (int i = 0; i < 260; i++) tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        vectors++;
        if (bus.err_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL err_cnt_saturate: got %0d, want 255", bus.err_cnt);
        end
    endtask

    task automatic test_backpressure();
        exp_t        q[$];
        logic [31:0] held_ins;
        logic        held_err;
        apply_reset();
        bus.out_ready = 1'b0;
        set_req(1'b1, 3'b000, 7'h13, 5'd7, 3'd2, 5'd3, 5'd0, 32'hFFFFF800);
        q.push_back(exp_word(3'b000, 7'h13, 5'd7, 3'd2, 5'd3, 5'd0, 32'hFFFFF800));
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_accept_a: got in_ready=%b, want 1", bus.in_ready);
        end
        tick();
        set_req(1'b1, 3'b001, 7'h23, 5'd0, 3'd2, 5'd9, 5'd17, 32'd1365);
        q.push_back(exp_word(3'b001, 7'h23, 5'd0, 3'd2, 5'd9, 5'd17, 32'd1365));
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_accept_b: got in_ready=%b, want 1", bus.in_ready);
        end
        tick();
        set_req(1'b1, 3'b010, 7'h63, 5'd0, 3'd1, 5'd12, 5'd30, 32'hFFFFF002);
        q.push_back(exp_word(3'b010, 7'h63, 5'd0, 3'd1, 5'd12, 5'd30, 32'hFFFFF002));
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full: got in_ready=%b, want 0", bus.in_ready);
        end
        tick();
        held_ins = bus.ins;
        held_err = bus.err;
        tick();
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.ins !== held_ins || bus.err !== held_err || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold: got v=%b ins=%h err=%b rdy=%b, want 1/%h/%b/0",
                     bus.out_valid, bus.ins, bus.err, bus.in_ready, held_ins, held_err);
        end
        bus.out_ready = 1'b1;
        #1;
        for (int n = 0; n < 8; n++) begin
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_extra_word: got ins=%h, want none", bus.ins);
                end else begin
                    if (bus.ins !== q[0].ins || bus.err !== q[0].err) begin
                        miscompares++;
                        $display("FAIL bp_order: got ins=%h err=%b, want %h/%b", bus.ins, bus.err, q[0].ins, q[0].err);
                    end
                    void'(q.pop_front());
                end
            end
            tick();
            if (n == 0) bus.in_valid = 1'b0;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_lost: got %0d words missing, want 0", q.size());
        end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        int          popped_err;
        int          want_cnt;
        logic [31:0] imm;
        apply_reset();
        popped_err = 0;
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: imm = $urandom() & 32'hFFFFF000;
                2: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
                default: imm = $urandom();
            endcase
            set_req(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 7'($urandom()),
                    5'($urandom()), 3'($urandom()), 5'($urandom()), 5'($urandom()), imm);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            #1;
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_spurious: got ins=%h, want no word", bus.ins);
                end else begin
                    want_cnt = popped_err + (q[0].err ? 1 : 0);
                    if (want_cnt > 255) want_cnt = 255;
                    if (bus.ins !== q[0].ins || bus.err !== q[0].err || bus.err_cnt !== 8'(want_cnt)) begin
                        miscompares++;
                        $display("FAIL rnd_word: got ins=%h err=%b cnt=%0d, want %h/%b/%0d",
                                 bus.ins, bus.err, bus.err_cnt, q[0].ins, q[0].err, want_cnt);
                    end
                    if (bus.out_ready) begin
                        if (q[0].err) popped_err++;
                        void'(q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = exp_word(bus.fmt, bus.opcode, bus.rd, bus.funct3, bus.rs1, bus.rs2, bus.imm);
                q.push_back(e);
            end
            vectors++;
            if (q.size() > 2) begin
                miscompares++;
                $display("FAIL rnd_occupancy: got %0d buffered, want <= 2", q.size());
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10 && q.size() > 0; n++) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (bus.ins !== q[0].ins || bus.err !== q[0].err) begin
                    miscompares++;
                    $display("FAIL rnd_drain: got ins=%h err=%b, want %h/%b", bus.ins, bus.err, q[0].ins, q[0].err);
                end
                void'(q.pop_front());
            end
            tick();
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL rnd_timeout: got %0d words undelivered, want 0", q.size());
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        apply_reset();
        bus.out_ready = 1'b0;
        set_req(1'b1, 3'b111, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd0);
        tick();
        set_req(1'b1, 3'b000, 7'h13, 5'd2, 3'd0, 5'd1, 5'd0, 32'd3);
        tick();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.err_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL mid_setup: got v=%b cnt=%0d, want 1/1", bus.out_valid, bus.err_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.err_cnt !== 8'd0 || bus.ins !== 32'h0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got v=%b cnt=%0d ins=%h err=%b, want 0/0/0/0",
                     bus.out_valid, bus.err_cnt, bus.ins, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.out_valid !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_no_ghost: got %0d stale words rdy=%b, want 0/1", seen, bus.in_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        set_req(1'b0, 3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 32'd0);
        test_reset();
        test_directed();
        test_errors();
        test_backpressure();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
